// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the fetch/MEM memory-port arbiter: master IDs,
// FSM state encodings and the muxed per-request control fields.
package mem_req_arbiter_pkg;

  localparam logic [0:0] ID_INST = 1'b0;
  localparam logic [0:0] ID_DATA = 1'b1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  typedef struct packed {
    logic       wr;
    logic [1:0] size;
    logic [3:0] wstrb;
  } req_ctrl_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundle of the fetch, MEM and shared sram-like port signals around the
// arbiter; slave is the arbiter's view, master is the surrounding system's view.
interface mem_req_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic              inst_req;
  logic [1:0]        inst_size;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [ADDR_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [ADDR_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [ADDR_W-1:0] data_rdata;

  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [ADDR_W-1:0] mem_rdata;

  modport slave (
    input  inst_req, inst_size, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_size, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );

endinterface

// File: rtl/mem_req_arbiter_arb_id_fifo.sv
// In-order queue of 1-bit master IDs for accepted transactions still waiting
// for their response; pointers wrap modulo DEPTH, which need not be a power of two.
module arb_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_push_id,
  input  logic                       i_pop,
  output logic                       o_head_id,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == {CNT_W{1'b0}});
  assign o_count   = r_count;
  assign o_head_id = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // Storage, wrap-around pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem    <= {DEPTH{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_id;
        r_wr_ptr        <= f_next_ptr(r_wr_ptr);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= f_next_ptr(r_rd_ptr);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one sram-like port between fetch (read-only) and MEM (read/write),
// holding a stalled grant and routing in-order responses by queued master ID.
// Build macro ARB_RR_EN selects round-robin instead of fixed data-over-inst priority.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = 2,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  mem_req_arbiter_if.slave     io_bus
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  logic [0:0]       r_state;
  logic             r_owner;
`ifdef ARB_RR_EN
  logic             r_last;
`endif

  logic             w_gnt;
  logic             w_owner_req;
  logic             w_req_raw;
  logic             w_full;
  logic             w_mem_req;
  logic             w_hs;
  logic             w_pop;
  logic             w_head_id;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_count;
  req_ctrl_t        w_ctrl;

  // Grant: a held grant stays with its owner; otherwise arbitrate between requesters
  always_comb begin
    w_gnt = ID_INST;
    if (r_state == ST_HOLD) begin
      w_gnt = r_owner;
    end else if (io_bus.data_req && io_bus.inst_req) begin
`ifdef ARB_RR_EN
      w_gnt = (r_last == ID_DATA) ? ID_INST : ID_DATA;
`else
      w_gnt = ID_DATA;
`endif
    end else if (io_bus.data_req) begin
      w_gnt = ID_DATA;
    end else begin
      w_gnt = ID_INST;
    end
  end

  assign w_owner_req = (w_gnt == ID_DATA) ? io_bus.data_req : io_bus.inst_req;
  assign w_req_raw   = (r_state == ST_HOLD) ? w_owner_req
                                            : (io_bus.inst_req | io_bus.data_req);
  // No bypass: a pop in the same cycle does not free a slot for this request
  assign w_full      = (w_count == CNT_W'(MAX_OUTST));
  assign w_mem_req   = w_req_raw & ~w_full;
  assign w_hs        = w_mem_req & io_bus.mem_addr_ok;
  assign w_pop       = io_bus.mem_data_ok & ~w_fifo_empty;

  // Control fields of the granted master; fetch never writes
  always_comb begin
    w_ctrl = '{wr: 1'b0, size: 2'b00, wstrb: 4'b0000};
    if (w_gnt == ID_DATA) begin
      w_ctrl = '{wr: io_bus.data_wr, size: io_bus.data_size, wstrb: io_bus.data_wstrb};
    end else begin
      w_ctrl = '{wr: 1'b0, size: io_bus.inst_size, wstrb: 4'b0000};
    end
  end

  // IDLE/HOLD: keep the grant on a stalled owner until accepted or withdrawn
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_owner <= ID_INST;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mem_req && !io_bus.mem_addr_ok) begin
            r_state <= ST_HOLD;
            r_owner <= w_gnt;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!w_owner_req || io_bus.mem_addr_ok) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_HOLD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_RR_EN
  // Last handshake winner; the other master gets priority on the next tie
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last <= ID_INST;
    end else if (w_hs) begin
      r_last <= w_gnt;
    end else begin
      r_last <= r_last;
    end
  end
`endif

  arb_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .i_push    (w_hs & ~w_fifo_full),
    .i_push_id (w_gnt),
    .i_pop     (w_pop),
    .o_head_id (w_head_id),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_count)
  );

  assign io_bus.mem_req   = resetn & w_mem_req;
  assign io_bus.mem_wr    = resetn & w_ctrl.wr;
  assign io_bus.mem_size  = resetn ? w_ctrl.size  : 2'b00;
  assign io_bus.mem_wstrb = resetn ? w_ctrl.wstrb : 4'b0000;
  assign io_bus.mem_addr  = !resetn ? {ADDR_W{1'b0}} :
                            (w_gnt == ID_DATA) ? io_bus.data_addr : io_bus.inst_addr;
  assign io_bus.mem_wdata = (resetn && (w_gnt == ID_DATA)) ? io_bus.data_wdata
                                                           : {ADDR_W{1'b0}};

  assign io_bus.inst_addr_ok = resetn & w_hs & (w_gnt == ID_INST);
  assign io_bus.data_addr_ok = resetn & w_hs & (w_gnt == ID_DATA);
  assign io_bus.inst_data_ok = resetn & w_pop & (w_head_id == ID_INST);
  assign io_bus.data_data_ok = resetn & w_pop & (w_head_id == ID_DATA);
  assign io_bus.inst_rdata   = resetn ? io_bus.mem_rdata : {ADDR_W{1'b0}};
  assign io_bus.data_rdata   = resetn ? io_bus.mem_rdata : {ADDR_W{1'b0}};

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed and random checks of mem_req_arbiter against a queue-based reference
// model; honours ARB_RR_EN when the design is built with it.
module tb_mem_req_arbiter;

  localparam int MAX_OUTST = 2;
  localparam int ADDR_W    = 32;

  logic clk;
  logic resetn;
  int   n_err;
  int   n_chk;

  int   q[$];
  bit   locked;
  bit   lock_owner;
  bit   last_data;
  bit   e_gd, e_oreq, e_mreq, e_hs, e_pop;

  mem_req_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_req_arbiter #(.MAX_OUTST(MAX_OUTST), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit ir, input bit dr, input bit dwr,
                        input bit maok, input bit mdok, input logic [31:0] rdata);
    bus.inst_req    = ir;
    bus.inst_size   = 2'($urandom_range(0, 3));
    bus.inst_addr   = $urandom;
    bus.data_req    = dr;
    bus.data_wr     = dwr;
    bus.data_size   = 2'($urandom_range(0, 3));
    bus.data_wstrb  = 4'($urandom_range(0, 15));
    bus.data_addr   = $urandom;
    bus.data_wdata  = $urandom;
    bus.mem_addr_ok = maok;
    bus.mem_data_ok = mdok;
    bus.mem_rdata   = rdata;
  endtask

  task automatic model_clear();
    q.delete();
    locked     = 1'b0;
    lock_owner = 1'b0;
    last_data  = 1'b0;
  endtask

  // Predict this cycle's outputs from the model and compare every output group
  task automatic eval();
    int           sz;
    bit           full;
    bit           head;
    logic [71:0]  e_bus;
    logic [3:0]   e_ok;
    logic [63:0]  e_rd;
    #2;
    sz   = q.size();
    full = (sz >= MAX_OUTST);
    head = (sz > 0) ? q[0][0] : 1'b0;
    if (locked) begin
      e_gd   = lock_owner;
      e_oreq = e_gd ? bus.data_req : bus.inst_req;
      e_mreq = e_oreq & !full;
    end else begin
`ifdef ARB_RR_EN
      if (bus.inst_req && bus.data_req) e_gd = !last_data;
      else e_gd = bus.data_req;
`else
      e_gd = bus.data_req;
`endif
      e_oreq = e_gd ? bus.data_req : bus.inst_req;
      e_mreq = (bus.inst_req | bus.data_req) & !full;
    end
    e_hs  = e_mreq & bus.mem_addr_ok;
    e_pop = bus.mem_data_ok && (sz > 0);
    if (e_gd)
      e_bus = {e_mreq, bus.data_wr, bus.data_size, bus.data_wstrb, bus.data_addr, bus.data_wdata};
    else
      e_bus = {e_mreq, 1'b0, bus.inst_size, 4'b0000, bus.inst_addr, 32'h0};
    e_ok = {e_hs & !e_gd, e_hs & e_gd, e_pop & !head, e_pop & head};
    e_rd = {bus.mem_rdata, bus.mem_rdata};
    if (!resetn) begin
      e_bus = 72'h0;
      e_ok  = 4'h0;
      e_rd  = 64'h0;
    end
    check("mem_bus", {bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_wstrb,
                      bus.mem_addr, bus.mem_wdata}, e_bus);
    check("handshakes", {bus.inst_addr_ok, bus.data_addr_ok,
                         bus.inst_data_ok, bus.data_data_ok}, e_ok);
    check("rdata", {bus.inst_rdata, bus.data_rdata}, e_rd);
  endtask

  // Clock edge: advance the model by the handshakes predicted in eval
  task automatic advance();
    @(posedge clk);
    if (resetn) begin
      if (e_pop) void'(q.pop_front());
      if (e_hs) begin
        q.push_back(int'(e_gd));
        last_data = e_gd;
      end
      if (!locked) begin
        if (e_mreq && !bus.mem_addr_ok) begin
          locked     = 1'b1;
          lock_owner = e_gd;
        end
      end else if (!e_oreq || bus.mem_addr_ok) begin
        locked = 1'b0;
      end
    end else begin
      model_clear();
    end
    #1;
  endtask

  task automatic step();
    eval();
    advance();
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    model_clear();
    resetn = 1'b0;
    set_in(1, 1, 1, 1, 1, 32'h1234_5678);

    // Reset: everything quiet even with both masters requesting
    eval();
    check("rst_mem_req", bus.mem_req, 1'b0);
    advance();
    advance();
    resetn = 1'b1;

    // Both request: data wins, inst follows next cycle
    set_in(1, 1, 1, 1, 0, 32'h0);
    eval();
    check("prio_data_aok", {bus.data_addr_ok, bus.inst_addr_ok, bus.mem_wr}, 3'b101);
    advance();
    set_in(1, 0, 0, 1, 0, 32'h0);
    eval();
    check("prio_inst_next", bus.inst_addr_ok, 1'b1);
    advance();
    set_in(0, 0, 0, 0, 1, 32'h11); step();
    set_in(0, 0, 0, 0, 1, 32'h22); step();

    // Stalled inst holds the grant while data_req rises
    set_in(1, 0, 0, 0, 0, 32'h0); step();
    set_in(1, 1, 1, 0, 0, 32'h0); step();
    set_in(1, 1, 1, 0, 0, 32'h0);
    eval();
    check("hold_inst_addr", bus.mem_addr, bus.inst_addr);
    advance();
    set_in(1, 1, 1, 1, 0, 32'h0);
    eval();
    check("hold_release", {bus.inst_addr_ok, bus.data_addr_ok}, 2'b10);
    advance();
    set_in(0, 1, 0, 1, 0, 32'h0);
    eval();
    check("hold_then_data", bus.data_addr_ok, 1'b1);
    advance();
    set_in(0, 0, 0, 0, 1, 32'h33); step();
    set_in(0, 0, 0, 0, 1, 32'h44); step();

    // Full queue blocks mem_req, including the popping cycle
    set_in(1, 0, 0, 1, 0, 32'h0); step();
    set_in(1, 0, 0, 1, 0, 32'h0); step();
    set_in(1, 0, 0, 1, 0, 32'h0);
    eval();
    check("full_blocks", {bus.mem_req, bus.inst_addr_ok}, 2'b00);
    advance();
    set_in(1, 0, 0, 1, 1, 32'h55);
    eval();
    check("full_no_bypass", {bus.mem_req, bus.inst_data_ok}, 2'b01);
    advance();
    set_in(1, 0, 0, 1, 0, 32'h0);
    eval();
    check("full_reissue", bus.mem_req, 1'b1);
    advance();
    set_in(0, 0, 0, 0, 1, 32'h66); step();
    set_in(0, 0, 0, 0, 1, 32'h77); step();

    // Interleaved inst, data, inst with in-order responses
    set_in(1, 0, 0, 1, 0, 32'h0); step();
    set_in(0, 1, 0, 1, 0, 32'h0); step();
    set_in(0, 0, 0, 0, 1, 32'hA);
    eval();
    check("ilv_inst_a", {bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata}, {2'b10, 32'hA});
    advance();
    set_in(1, 0, 0, 1, 0, 32'h0); step();
    set_in(0, 0, 0, 0, 1, 32'hB);
    eval();
    check("ilv_data_b", {bus.inst_data_ok, bus.data_data_ok, bus.data_rdata}, {2'b01, 32'hB});
    advance();
    set_in(0, 0, 0, 0, 1, 32'hC);
    eval();
    check("ilv_inst_c", {bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata}, {2'b10, 32'hC});
    advance();

    // Response with empty queue is dropped
    set_in(0, 0, 0, 0, 1, 32'hDD);
    eval();
    check("empty_drop", {bus.inst_data_ok, bus.data_data_ok}, 2'b00);
    advance();
    set_in(1, 0, 0, 1, 0, 32'h0); step();
    set_in(1, 0, 0, 0, 0, 32'h0);
    eval();
    check("count_after_drop", bus.mem_req, 1'b1);
    advance();

    // Reset mid-flight while inst holds the grant
    set_in(1, 0, 0, 0, 0, 32'h0);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_quiet", {bus.mem_req, bus.inst_addr_ok, bus.mem_addr}, 34'h0);
    model_clear();
    eval();
    advance();
    resetn = 1'b1;
    set_in(0, 0, 0, 0, 1, 32'hEE);
    eval();
    check("late_resp_drop", {bus.inst_data_ok, bus.data_data_ok}, 2'b00);
    advance();
    set_in(0, 1, 1, 1, 0, 32'h0);
    eval();
    check("post_rst_idle", bus.data_addr_ok, 1'b1);
    advance();
    set_in(0, 0, 0, 0, 1, 32'h0); step();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, $urandom);
      step();
    end

    // Fresh reset, then both masters requesting every cycle
    resetn = 1'b0;
    set_in(0, 0, 0, 0, 0, 32'h0);
    step();
    resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_in(1, 1, 0, 1, 1, $urandom);
      eval();
`ifdef ARB_RR_EN
      check("rr_alternate", bus.data_addr_ok, (k % 2) == 0);
`else
      check("fixed_prio", bus.data_addr_ok, 1'b1);
`endif
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
Shares one sram-like memory port between the fetch stage (read-only) and the MEM stage (read/write) of the five-stage core. It grants address phases, tracks up to MAX_OUTST accepted-but-unanswered transactions in an in-order ID queue, and routes each data_ok/rdata back to the issuing master. It sits between the pipeline stages and the sram-to-AXI bridge.

Parameters:
MAX_OUTST, 2, max accepted transactions awaiting data_ok (1..4)
ADDR_W, 32, address/data width

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
inst_req  in  1  fetch request
inst_size  in  2  fetch size
inst_addr  in  32  fetch address
inst_addr_ok  out  1  fetch address accepted
inst_data_ok  out  1  fetch data returned
inst_rdata  out  32  fetch read data
data_req  in  1  MEM request
data_wr  in  1  1=write
data_size  in  2  MEM size
data_wstrb  in  4  byte strobes
data_addr  in  32  MEM address
data_wdata  in  32  write data
data_addr_ok  out  1  MEM address accepted
data_data_ok  out  1  MEM response (read data or write ack)
data_rdata  out  32  MEM read data
mem_req  out  1  shared-port request
mem_wr  out  1  write flag
mem_size  out  2  size
mem_wstrb  out  4  strobes (0 for fetch)
mem_addr  out  32  address
mem_wdata  out  32  write data (0 for fetch)
mem_addr_ok  in  1  address accepted by bridge
mem_data_ok  in  1  response valid
mem_rdata  in  32  response data

Behaviour:
- Asynchronous reset: FSM=IDLE, queue empty, count=0; all outputs 0 during reset.
- Grant (combinational in IDLE): data_req wins over inst_req (older instruction). Selected master's fields are driven on mem_*; mem_req = (inst_req|data_req) & ~full.
- FSM IDLE/HOLD: IDLE with mem_req & ~mem_addr_ok -> HOLD, owner register latched. In HOLD, grant stays on the owner even if the other master raises req; HOLD -> IDLE on mem_addr_ok, or when the owner drops req (withdrawal allowed, no transaction recorded).
- addr_ok: only the granted master sees mem_addr_ok, same cycle, zero added latency. Handshake = mem_req & mem_addr_ok; push owner ID (0=inst, 1=data) into the queue.
- Response: mem_data_ok pops the head. inst_data_ok = mem_data_ok & head==0; data_data_ok = mem_data_ok & head==1. rdata is mem_rdata to both masters, unregistered.
- Full: count==MAX_OUTST gives mem_req=0, even in a cycle that also pops (no bypass). The request is re-issued the next cycle.
- Push and pop in the same cycle (not full): count unchanged, pointers both advance, modulo MAX_OUTST wrap.
- mem_data_ok with empty queue: dropped, no master sees data_ok, count stays 0.
- Responses are strictly in order; the bridge guarantees in-order return.
- Reset asserted mid-transaction clears the queue; late responses after release fall under the empty-queue rule.

Optional Feature:
ARB_RR_EN: defined gives round-robin. A last-winner bit, updated on each handshake, gives priority to the other master when both request. Undefined gives fixed data-over-inst priority, and the bit is not built.

Decomposition:
- Shared package holds: master ID constants (ID_INST=0, ID_DATA=1) and FSM state encodings.
- One sub-module, arb_id_fifo (parameterised depth, 1-bit payload, push/pop/full/empty/count, async active-low reset), holds the queue.

Test Plan:
- Both req same cycle, addr_ok=1 -> data granted (mem_wr follows data_wr), inst_addr_ok=0; inst granted next cycle.
- inst_req, mem_addr_ok low 3 cycles, data_req rises in cycle 2 -> grant stays inst (HOLD); inst_addr_ok on cycle 4, then data granted.
- MAX_OUTST=2: two accepted fetches, no data_ok -> mem_req=0 with inst_req high; one data_ok -> inst_data_ok=1, mem_req=1 next cycle.
- Interleaved accepts inst, data, inst; responses rdata 0xA,0xB,0xC -> inst gets 0xA, data gets 0xB, inst gets 0xC.
- mem_data_ok with empty queue -> no data_ok asserted, count stays 0; resetn low mid-flight -> count=0, FSM=IDLE immediately.
- ARB_RR_EN defined, both masters req continuously with addr_ok=1 -> grants alternate data, inst, data, inst.
